// File: rtl/step_sched_pkg.sv
// Shared types and helpers for the XY step scheduler (axis FSM states, direction encoding).
// Purely declarative: no timing and no backpressure.
package step_sched_pkg;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SETUP = 2'd1,
    PULSE = 2'd2,
    WAIT  = 2'd3
  } axis_state_t;

  localparam logic DIR_POS = 1'b1;
  localparam logic DIR_NEG = 1'b0;

  localparam int CNT_W = 32;

  // Step period actually used: the programmed speed, never shorter than the driver minimum.
  function automatic logic [CNT_W-1:0] eff_period(input logic [CNT_W-1:0] speed,
                                                  input logic [CNT_W-1:0] min_period);
    return (speed < min_period) ? min_period : speed;
  endfunction

endpackage

// File: rtl/axis_stepper.sv
// One stepper axis: dir/step FSM, period timer, signed position counter; step rises the cycle after speed is seen
// (DIR_SETUP cycles later on a reversal). No backpressure. SOFT_LIMIT_EN adds position bounds and lim_hit_o.
module axis_stepper
  import step_sched_pkg::*;
#(
  parameter int                      POS_W      = 32,
  parameter int                      PULSE_W    = 100,
  parameter int                      DIR_SETUP  = 50,
  parameter int                      MIN_PERIOD = 1000,
  parameter logic signed [POS_W-1:0] LIM_MIN    = -32'sd100000,
  parameter logic signed [POS_W-1:0] LIM_MAX    = 32'sd100000
) (
  input  logic                    clk_i,
  input  logic                    rst_ni,
  input  logic [CNT_W-1:0]        speed_i,
  input  logic                    dir_i,
  input  logic                    zero_i,
  output logic                    step_o,
  output logic                    dir_o,
  output logic signed [POS_W-1:0] pos_o,
  output logic                    busy_o,
  output logic                    lim_hit_o
);

  localparam logic [CNT_W-1:0] PW_M1   = CNT_W'(PULSE_W - 1);
  localparam logic [CNT_W-1:0] DS_M1   = CNT_W'(DIR_SETUP - 1);
  localparam logic [CNT_W-1:0] MINP    = CNT_W'(MIN_PERIOD);
  localparam logic [POS_W-1:0] POS_ONE = {{(POS_W-1){1'b0}}, 1'b1};

  if (PULSE_W < 1 || DIR_SETUP < 1 || MIN_PERIOD < PULSE_W + DIR_SETUP + 1) begin : g_bad_timing
    $error("axis_stepper: timing parameters out of range");
  end
  if (LIM_MIN > LIM_MAX) begin : g_bad_limits
    $error("axis_stepper: LIM_MIN above LIM_MAX");
  end

  axis_state_t             state_q, state_d;
  logic [CNT_W-1:0]        el_q, el_d;
  logic [CNT_W-1:0]        period_q, period_d;
  logic                    dir_q, dir_d;
  logic signed [POS_W-1:0] pos_q, pos_d;
  logic signed [POS_W-1:0] pos_step;
  logic                    rise;
  logic                    resample;
  logic                    allow;

  // el_q counts cycles since entering the current SETUP or step period.
  always_comb begin
    state_d  = state_q;
    el_d     = el_q + 32'd1;
    period_d = period_q;
    dir_d    = dir_q;
    rise     = 1'b0;
    resample = 1'b0;
    case (state_q)
      IDLE: begin
        el_d     = '0;
        resample = (speed_i != '0);
      end
      SETUP: rise = (el_q == DS_M1);
      PULSE: if (el_q == PW_M1) state_d = WAIT;
      WAIT: begin
        if (el_q == period_q - 32'd1) begin
          if (speed_i == '0) state_d = IDLE;
          else               resample = 1'b1;
        end
      end
      default: state_d = IDLE;
    endcase
    if (resample) begin
      if (dir_i != dir_q) begin
        state_d = SETUP;
        dir_d   = dir_i;
        el_d    = '0;
      end else begin
        rise = 1'b1;
      end
    end
    if (rise) begin
      state_d  = PULSE;
      el_d     = '0;
      period_d = eff_period(speed_i, MINP);
    end
  end

  assign pos_step = (dir_q == DIR_POS) ? (pos_q + POS_ONE) : (pos_q - POS_ONE);

  always_comb begin
    pos_d = pos_q;
    if (zero_i)              pos_d = '0;
    else if (rise && allow)  pos_d = pos_step;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= IDLE;
      el_q     <= '0;
      period_q <= '0;
      dir_q    <= DIR_NEG;
      pos_q    <= '0;
    end else begin
      state_q  <= state_d;
      el_q     <= el_d;
      period_q <= period_d;
      dir_q    <= dir_d;
      pos_q    <= pos_d;
    end
  end

`ifdef SOFT_LIMIT_EN
  // A suppressed step still runs its full period; only the pin and the count are withheld.
  logic supp_q, supp_d;
  logic lim_q, lim_d;

  assign allow = (pos_step >= LIM_MIN) && (pos_step <= LIM_MAX);

  always_comb begin
    supp_d = supp_q;
    lim_d  = lim_q;
    if (rise) begin
      supp_d = !allow;
      lim_d  = !allow;
    end
    if (zero_i) lim_d = 1'b0;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      supp_q <= 1'b0;
      lim_q  <= 1'b0;
    end else begin
      supp_q <= supp_d;
      lim_q  <= lim_d;
    end
  end

  assign step_o    = (state_q == PULSE) && !supp_q;
  assign lim_hit_o = lim_q;
`else
  assign allow     = 1'b1;
  assign step_o    = (state_q == PULSE);
  assign lim_hit_o = 1'b0;
`endif

  assign dir_o  = dir_q;
  assign pos_o  = pos_q;
  assign busy_o = (state_q != IDLE);

endmodule

// File: rtl/xy_step_scheduler.sv
// Two independent step/dir generators driven by the speed/direction registers, with X/Y position feedback.
// Step rises the cycle after speed is seen; no backpressure. Define SOFT_LIMIT_EN for soft position limits.
module xy_step_scheduler
  import step_sched_pkg::*;
#(
  parameter int                      POS_W      = 32,
  parameter int                      PULSE_W    = 100,
  parameter int                      DIR_SETUP  = 50,
  parameter int                      MIN_PERIOD = 1000,
  parameter logic signed [POS_W-1:0] LIM_MIN    = -32'sd100000,
  parameter logic signed [POS_W-1:0] LIM_MAX    = 32'sd100000
) (
  input  logic                    clock,
  input  logic                    ctrl_reset,
  input  logic [CNT_W-1:0]        xSpeed,
  input  logic [CNT_W-1:0]        xDirection,
  input  logic [CNT_W-1:0]        ySpeed,
  input  logic [CNT_W-1:0]        yDirection,
  input  logic                    btn_CENTER,
  output logic                    step_x,
  output logic                    dir_x,
  output logic                    step_y,
  output logic                    dir_y,
  output logic signed [POS_W-1:0] currentX,
  output logic signed [POS_W-1:0] currentY,
  output logic                    busy,
  output logic [1:0]              lim_hit
);

  logic busy_x, busy_y;
  logic lim_x, lim_y;
  logic unused_dir_bits;

  // Only bit 0 of the direction registers carries meaning.
  assign unused_dir_bits = ^{xDirection[CNT_W-1:1], yDirection[CNT_W-1:1]};

  axis_stepper #(
    .POS_W(POS_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP),
    .MIN_PERIOD(MIN_PERIOD), .LIM_MIN(LIM_MIN), .LIM_MAX(LIM_MAX)
  ) u_axis_x (
    .clk_i(clock), .rst_ni(ctrl_reset), .speed_i(xSpeed), .dir_i(xDirection[0]),
    .zero_i(btn_CENTER), .step_o(step_x), .dir_o(dir_x), .pos_o(currentX),
    .busy_o(busy_x), .lim_hit_o(lim_x)
  );

  axis_stepper #(
    .POS_W(POS_W), .PULSE_W(PULSE_W), .DIR_SETUP(DIR_SETUP),
    .MIN_PERIOD(MIN_PERIOD), .LIM_MIN(LIM_MIN), .LIM_MAX(LIM_MAX)
  ) u_axis_y (
    .clk_i(clock), .rst_ni(ctrl_reset), .speed_i(ySpeed), .dir_i(yDirection[0]),
    .zero_i(btn_CENTER), .step_o(step_y), .dir_o(dir_y), .pos_o(currentY),
    .busy_o(busy_y), .lim_hit_o(lim_y)
  );

  assign busy    = busy_x | busy_y;
  assign lim_hit = {lim_y, lim_x};

endmodule

// File: tb/tb_xy_step_scheduler.sv
// Bench for xy_step_scheduler: directed timing scenarios plus randomized traffic against a timestamp model.
module tb_xy_step_scheduler;

  localparam int PW   = 4;
  localparam int DS   = 2;
  localparam int MINP = 8;
`ifdef SOFT_LIMIT_EN
  localparam bit                 LIM_ON = 1'b1;
  localparam logic signed [31:0] LMAX   = 32'sd2;
`else
  localparam bit                 LIM_ON = 1'b0;
  localparam logic signed [31:0] LMAX   = 32'sd100000;
`endif
  localparam logic signed [31:0] LMIN = -32'sd100000;

  logic               clock = 1'b0;
  logic               ctrl_reset;
  logic [31:0]        xSpeed, xDirection, ySpeed, yDirection;
  logic               btn_CENTER;
  logic               step_x, dir_x, step_y, dir_y, busy;
  logic signed [31:0] currentX, currentY;
  logic [1:0]         lim_hit;

  int errors = 0;
  int checks = 0;

  xy_step_scheduler #(
    .POS_W(32), .PULSE_W(PW), .DIR_SETUP(DS), .MIN_PERIOD(MINP), .LIM_MIN(LMIN), .LIM_MAX(LMAX)
  ) dut (
    .clock(clock), .ctrl_reset(ctrl_reset), .xSpeed(xSpeed), .xDirection(xDirection),
    .ySpeed(ySpeed), .yDirection(yDirection), .btn_CENTER(btn_CENTER),
    .step_x(step_x), .dir_x(dir_x), .step_y(step_y), .dir_y(dir_y),
    .currentX(currentX), .currentY(currentY), .busy(busy), .lim_hit(lim_hit)
  );

  always #5 clock = ~clock;

  // Reference model: per axis, the time of the last rise, the period boundary and the scheduled next rise.
  longint             cyc;
  bit                 m_idle  [2];
  logic               m_dir   [2];
  logic signed [31:0] m_pos   [2];
  longint             m_last  [2];
  longint             m_bound [2];
  longint             m_next  [2];
  bit                 m_supp  [2];
  bit                 m_lim   [2];
  longint             r_last;

  task automatic model_reset();
    for (int a = 0; a < 2; a++) begin
      m_idle[a] = 1'b1; m_dir[a] = 1'b0; m_pos[a] = 0;
      m_last[a] = -1000; m_bound[a] = -1; m_next[a] = -1;
      m_supp[a] = 1'b0; m_lim[a] = 1'b0;
    end
  endtask

  task automatic model_edge();
    cyc++;
    if (!ctrl_reset) begin
      model_reset();
      return;
    end
    for (int a = 0; a < 2; a++) begin
      logic [31:0]        spd;
      logic               d;
      logic signed [31:0] np;
      bit                 go;
      spd = (a == 0) ? xSpeed : ySpeed;
      d   = (a == 0) ? xDirection[0] : yDirection[0];
      go  = 1'b0;
      if (m_idle[a]) go = (spd != 0);
      else if (cyc == m_bound[a]) begin
        if (spd == 0) m_idle[a] = 1'b1;
        else          go = 1'b1;
      end
      if (go) begin
        m_idle[a] = 1'b0;
        if (d != m_dir[a]) begin
          m_dir[a]  = d;
          m_next[a] = cyc + DS;
        end else begin
          m_next[a] = cyc;
        end
      end
      if (!m_idle[a] && cyc == m_next[a]) begin
        m_last[a]  = cyc;
        m_next[a]  = -1;
        m_bound[a] = cyc + ((spd < 32'(MINP)) ? longint'(MINP) : longint'(spd));
        np = m_dir[a] ? m_pos[a] + 1 : m_pos[a] - 1;
        if (LIM_ON && (np < LMIN || np > LMAX)) begin
          m_supp[a] = 1'b1; m_lim[a] = 1'b1;
        end else begin
          m_supp[a] = 1'b0; m_lim[a] = 1'b0; m_pos[a] = np;
        end
      end
    end
    if (btn_CENTER) begin
      m_pos[0] = 0; m_pos[1] = 0; m_lim[0] = 1'b0; m_lim[1] = 1'b0;
    end
  endtask

  function automatic bit exp_step(int a);
    return !m_supp[a] && (cyc >= m_last[a]) && (cyc < m_last[a] + PW);
  endfunction

  task automatic tick();
    @(posedge clock);
    model_edge();
    #1;
  endtask

  task automatic test_reset();
    ctrl_reset = 1'b0;
    repeat (3) tick();
    checks++; if (step_x !== 1'b0)  begin errors++; $display("FAIL reset_step_x got %b want 0", step_x); end
    checks++; if (dir_x !== 1'b0)   begin errors++; $display("FAIL reset_dir_x got %b want 0", dir_x); end
    checks++; if (step_y !== 1'b0)  begin errors++; $display("FAIL reset_step_y got %b want 0", step_y); end
    checks++; if (dir_y !== 1'b0)   begin errors++; $display("FAIL reset_dir_y got %b want 0", dir_y); end
    checks++; if (currentX !== 0)   begin errors++; $display("FAIL reset_currentX got %0d want 0", currentX); end
    checks++; if (currentY !== 0)   begin errors++; $display("FAIL reset_currentY got %0d want 0", currentY); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL reset_busy got %b want 0", busy); end
    checks++; if (lim_hit !== 2'b0) begin errors++; $display("FAIL reset_lim_hit got %b want 00", lim_hit); end
    ctrl_reset = 1'b1;
    tick();
  endtask

  task automatic test_first_steps();
    longint rt[$];
    int     hi;
    bit     prev;
    xDirection = 32'h1; xSpeed = 32'd20;
    tick();
    checks++; if (dir_x !== 1'b1 || step_x !== 1'b0)
      begin errors++; $display("FAIL setup_dir got dir=%b step=%b want dir=1 step=0", dir_x, step_x); end
    tick();
    checks++; if (step_x !== 1'b0) begin errors++; $display("FAIL setup_hold got step=%b want 0", step_x); end
    tick();
    checks++; if (step_x !== 1'b1) begin errors++; $display("FAIL first_rise got step=%b want 1", step_x); end
    rt.push_back(cyc); prev = step_x; hi = 1;
    for (int i = 0; i < 120 && rt.size() < 5; i++) begin
      tick();
      if (step_x && !prev) begin rt.push_back(cyc); hi = 1; end
      else if (step_x) hi++;
      else if (prev) begin
        checks++; if (hi != PW) begin errors++; $display("FAIL pulse_width got %0d want %0d", hi, PW); end
      end
      prev = step_x;
    end
    checks++; if (rt.size() != 5) begin errors++; $display("FAIL rise_count got %0d want 5", rt.size()); end
    for (int k = 1; k < rt.size(); k++) begin
      checks++; if (rt[k] - rt[k-1] != 20)
        begin errors++; $display("FAIL period_20 got %0d want 20", rt[k] - rt[k-1]); end
    end
    checks++; if (currentX !== 5) begin errors++; $display("FAIL count_5 got %0d want 5", currentX); end
    r_last = rt[rt.size()-1];
  endtask

  task automatic test_reverse();
    longint t_dir, t_rise;
    repeat (6) tick();
    xDirection = 32'h0;
    t_dir = -1;
    for (int i = 0; i < 40; i++) begin tick(); if (dir_x === 1'b0) begin t_dir = cyc; break; end end
    checks++; if (t_dir != r_last + 20)
      begin errors++; $display("FAIL rev_dir_time got %0d want %0d", t_dir, r_last + 20); end
    t_rise = -1;
    for (int i = 0; i < 10; i++) begin tick(); if (step_x === 1'b1) begin t_rise = cyc; break; end end
    checks++; if (t_rise != r_last + 22)
      begin errors++; $display("FAIL rev_rise_time got %0d want %0d", t_rise, r_last + 22); end
    checks++; if (currentX !== 4) begin errors++; $display("FAIL rev_count got %0d want 4", currentX); end
    r_last = t_rise;
  endtask

  task automatic test_clamp();
    longint rt[$];
    bit     prev;
    xSpeed = 32'd3;
    prev = step_x;
    for (int i = 0; i < 100 && rt.size() < 3; i++) begin
      tick();
      if (step_x && !prev) rt.push_back(cyc);
      prev = step_x;
    end
    checks++; if (rt.size() != 3) begin errors++; $display("FAIL clamp_rises got %0d want 3", rt.size()); end
    for (int k = 1; k < rt.size(); k++) begin
      checks++; if (rt[k] - rt[k-1] != MINP)
        begin errors++; $display("FAIL clamp_period got %0d want %0d", rt[k] - rt[k-1], MINP); end
    end
    checks++; if (currentX !== 1) begin errors++; $display("FAIL clamp_count got %0d want 1", currentX); end
    if (rt.size() > 0) r_last = rt[rt.size()-1];
  endtask

  task automatic test_stop();
    longint t_idle;
    int     n;
    repeat (5) tick();
    xSpeed = 32'd0;
    t_idle = -1;
    for (int i = 0; i < 20; i++) begin tick(); if (busy === 1'b0) begin t_idle = cyc; break; end end
    checks++; if (t_idle != r_last + MINP)
      begin errors++; $display("FAIL stop_busy_fall got %0d want %0d", t_idle, r_last + MINP); end
    n = 0;
    repeat (30) begin tick(); if (step_x !== 1'b0) n++; end
    checks++; if (n != 0) begin errors++; $display("FAIL stop_no_pulse got %0d want 0", n); end
  endtask

  task automatic test_center();
    bit prev, done;
    int h;
    xDirection = 32'h1; xSpeed = 32'd8;
    prev = step_x; done = 1'b0;
    for (int i = 0; i < 200 && !done; i++) begin
      tick();
      if (step_x && !prev) r_last = cyc;
      prev = step_x;
      if (currentX == 7 && cyc == r_last + 7) begin
        btn_CENTER = 1'b1;
        tick();
        btn_CENTER = 1'b0;
        checks++; if (currentX !== 0) begin errors++; $display("FAIL center_zero got %0d want 0", currentX); end
        checks++; if (step_x !== 1'b1) begin errors++; $display("FAIL center_step got %b want 1", step_x); end
        h = 1;
        for (int j = 0; j < 10; j++) begin tick(); if (step_x) h++; else break; end
        checks++; if (h != PW) begin errors++; $display("FAIL center_width got %0d want %0d", h, PW); end
        done = 1'b1;
      end
    end
    checks++; if (!done) begin errors++; $display("FAIL center_reached got 0 want 1"); end
  endtask

  task automatic test_async_reset();
    bit found;
    found = 1'b0;
    for (int i = 0; i < 20; i++) begin tick(); if (step_x === 1'b1) begin found = 1'b1; break; end end
    checks++; if (!found) begin errors++; $display("FAIL areset_pulse got 0 want 1"); end
    #2 ctrl_reset = 1'b0;
    #1;
    checks++; if (step_x !== 1'b0)  begin errors++; $display("FAIL areset_step got %b want 0", step_x); end
    checks++; if (dir_x !== 1'b0)   begin errors++; $display("FAIL areset_dir got %b want 0", dir_x); end
    checks++; if (currentX !== 0)   begin errors++; $display("FAIL areset_pos got %0d want 0", currentX); end
    checks++; if (busy !== 1'b0)    begin errors++; $display("FAIL areset_busy got %b want 0", busy); end
    xSpeed = 32'd0; xDirection = 32'h0;
    model_reset();
    tick(); tick();
    ctrl_reset = 1'b1;
  endtask

`ifdef SOFT_LIMIT_EN
  task automatic test_soft_limit();
    int rises;
    bit prev;
    xSpeed = 32'd8; xDirection = 32'h1;
    rises = 0; prev = step_x;
    for (int i = 0; i < 60; i++) begin
      tick();
      if (step_x && !prev) rises++;
      prev = step_x;
    end
    checks++; if (rises != 2) begin errors++; $display("FAIL lim_rises got %0d want 2", rises); end
    checks++; if (currentX !== 2) begin errors++; $display("FAIL lim_count got %0d want 2", currentX); end
    checks++; if (lim_hit !== 2'b01) begin errors++; $display("FAIL lim_flag got %b want 01", lim_hit); end
    xDirection = 32'h0;
    for (int i = 0; i < 40; i++) begin tick(); if (currentX === 1) break; end
    checks++; if (currentX !== 1) begin errors++; $display("FAIL lim_back got %0d want 1", currentX); end
    checks++; if (lim_hit !== 2'b00) begin errors++; $display("FAIL lim_clear got %b want 00", lim_hit); end
  endtask
`endif

  task automatic test_random();
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 39) == 0) xSpeed = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      if ($urandom_range(0, 39) == 0) ySpeed = ($urandom_range(0, 3) == 0) ? 32'd0 : 32'($urandom_range(1, 30));
      if ($urandom_range(0, 29) == 0) xDirection = $urandom();
      if ($urandom_range(0, 29) == 0) yDirection = $urandom();
      btn_CENTER = ($urandom_range(0, 59) == 0);
      tick();
      checks++; if (step_x !== exp_step(0))
        begin errors++; $display("FAIL rnd_step_x cyc=%0d got %b want %b", cyc, step_x, exp_step(0)); end
      checks++; if (step_y !== exp_step(1))
        begin errors++; $display("FAIL rnd_step_y cyc=%0d got %b want %b", cyc, step_y, exp_step(1)); end
      checks++; if (dir_x !== m_dir[0])
        begin errors++; $display("FAIL rnd_dir_x cyc=%0d got %b want %b", cyc, dir_x, m_dir[0]); end
      checks++; if (dir_y !== m_dir[1])
        begin errors++; $display("FAIL rnd_dir_y cyc=%0d got %b want %b", cyc, dir_y, m_dir[1]); end
      checks++; if (currentX !== m_pos[0])
        begin errors++; $display("FAIL rnd_currentX cyc=%0d got %0d want %0d", cyc, currentX, m_pos[0]); end
      checks++; if (currentY !== m_pos[1])
        begin errors++; $display("FAIL rnd_currentY cyc=%0d got %0d want %0d", cyc, currentY, m_pos[1]); end
      checks++; if (busy !== !(m_idle[0] && m_idle[1]))
        begin errors++; $display("FAIL rnd_busy cyc=%0d got %b want %b", cyc, busy, !(m_idle[0] && m_idle[1])); end
      checks++; if (lim_hit !== {m_lim[1], m_lim[0]})
        begin errors++; $display("FAIL rnd_lim_hit cyc=%0d got %b want %b%b", cyc, lim_hit, m_lim[1], m_lim[0]); end
    end
    btn_CENTER = 1'b0;
  endtask

  initial begin
    ctrl_reset = 1'b0;
    xSpeed = 32'd0; xDirection = 32'h0; ySpeed = 32'd0; yDirection = 32'h0;
    btn_CENTER = 1'b0;
    cyc = 0; r_last = 0;
    model_reset();
    test_reset();
    test_first_steps();
    test_reverse();
    test_clamp();
    test_stop();
    test_center();
    test_async_reset();
`ifdef SOFT_LIMIT_EN
    test_soft_limit();
`endif
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
